// File: rtl/posit_ccip_rd_bridge.sv
// posit_ccip_rd_bridge: turns FU element-index reads into CCI-P c0 RDLINE
// requests. A slot table keeps the FU tag and the element lane for each
// request in flight, so responses can return in any order.
module posit_ccip_rd_bridge #(
  parameter int ELEM_W          = 32,
  parameter int CL_W            = 512,
  parameter int ADDR_W          = 42,
  parameter int FU_ADDR_W       = 8,
  parameter int GRAN_W          = 8,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int SLOT_W         = $clog2(MAX_OUTSTANDING)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [GRAN_W-1:0]    cfg_stride,
  input  logic                 fu_req_valid,
  output logic                 fu_req_ready,
  input  logic [FU_ADDR_W-1:0] fu_req_addr,
  input  logic [TAG_W-1:0]     fu_req_tag,
  output logic                 c0_req_valid,
  output logic [ADDR_W-1:0]    c0_req_addr,
  output logic [15:0]          c0_req_mdata,
  input  logic                 c0_almfull,
  input  logic                 c0_rsp_valid,
  input  logic [15:0]          c0_rsp_mdata,
  input  logic [CL_W-1:0]      c0_rsp_data,
  output logic                 fu_rsp_valid,
  output logic [TAG_W-1:0]     fu_rsp_tag,
  output logic [ELEM_W-1:0]    fu_rsp_data,
  output logic [SLOT_W:0]      outstanding,
  output logic                 err_unknown_tag
);

  localparam int BO_W   = GRAN_W + FU_ADDR_W;
  localparam int NLANE  = CL_W / ELEM_W;
  localparam int LANE_W = $clog2(NLANE);
  localparam int ESH    = $clog2(ELEM_W / 8);

  typedef logic [NLANE-1:0][ELEM_W-1:0] line_t;

  // slot table
  logic [MAX_OUTSTANDING-1:0]              occ_q, occ_d;
  logic [MAX_OUTSTANDING-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [MAX_OUTSTANDING-1:0][LANE_W-1:0]  lane_q, lane_d;
  logic [SLOT_W:0]                         cnt_q, cnt_d;

  // registered outputs
  logic                c0_req_valid_q, c0_req_valid_d;
  logic [ADDR_W-1:0]   c0_req_addr_q, c0_req_addr_d;
  logic [15:0]         c0_req_mdata_q, c0_req_mdata_d;
  logic                fu_rsp_valid_q, fu_rsp_valid_d;
  logic [TAG_W-1:0]    fu_rsp_tag_q, fu_rsp_tag_d;
  logic [ELEM_W-1:0]   fu_rsp_data_q, fu_rsp_data_d;
  logic                err_q, err_d;

  // combinational helpers
  logic [BO_W-1:0]     byte_off;
  logic [5:0]          lane_b;
  logic [LANE_W-1:0]   req_lane;
  logic [SLOT_W-1:0]   alloc_idx;
  logic                have_free;
  logic                accept;
  logic [SLOT_W-1:0]   rsp_slot;
  logic                rsp_hit;
  logic                rsp_miss;
  line_t               rsp_line;
  logic                unused_bits;

  // Upper mdata bits carry nothing for us; only the slot field is decoded.
  assign unused_bits = ^{c0_rsp_mdata[15:SLOT_W], lane_b};

  // Address/lane math, slot allocation, response lookup and next-state.
  always_comb begin
    byte_off  = BO_W'(cfg_stride) * BO_W'(fu_req_addr);
    lane_b    = byte_off[5:0] >> ESH;
    req_lane  = lane_b[LANE_W-1:0];

    // Lowest free slot, judged on the table as it stood at cycle start so a
    // slot freed this cycle is only reusable next cycle.
    have_free = ~&occ_q;
    alloc_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_idx = SLOT_W'(i);
    end

    fu_req_ready = !reset && have_free && !c0_almfull;
    accept       = fu_req_valid && fu_req_ready;

    rsp_slot = c0_rsp_mdata[SLOT_W-1:0];
    rsp_hit  = c0_rsp_valid && occ_q[rsp_slot];
    rsp_miss = c0_rsp_valid && !occ_q[rsp_slot];
    rsp_line = c0_rsp_data;

    occ_d          = occ_q;
    tag_d          = tag_q;
    lane_d         = lane_q;
    c0_req_valid_d = 1'b0;
    c0_req_addr_d  = c0_req_addr_q;
    c0_req_mdata_d = c0_req_mdata_q;
    fu_rsp_valid_d = 1'b0;
    fu_rsp_tag_d   = fu_rsp_tag_q;
    fu_rsp_data_d  = fu_rsp_data_q;
    err_d          = err_q || rsp_miss;

    if (rsp_hit) begin
      occ_d[rsp_slot] = 1'b0;
      fu_rsp_valid_d  = 1'b1;
      fu_rsp_tag_d    = tag_q[rsp_slot];
      fu_rsp_data_d   = rsp_line[lane_q[rsp_slot]];
    end

    // The allocated slot was free at cycle start, so it never collides with
    // the slot being released above.
    if (accept) begin
      occ_d[alloc_idx]  = 1'b1;
      tag_d[alloc_idx]  = fu_req_tag;
      lane_d[alloc_idx] = req_lane;
      c0_req_valid_d    = 1'b1;
      c0_req_addr_d     = cfg_base_addr + ADDR_W'(byte_off[BO_W-1:6]);
      c0_req_mdata_d    = 16'(alloc_idx);
    end

    cnt_d = cnt_q + (SLOT_W+1)'(accept) - (SLOT_W+1)'(rsp_hit);
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q          <= '0;
      tag_q          <= '0;
      lane_q         <= '0;
      cnt_q          <= '0;
      c0_req_valid_q <= 1'b0;
      c0_req_addr_q  <= '0;
      c0_req_mdata_q <= '0;
      fu_rsp_valid_q <= 1'b0;
      fu_rsp_tag_q   <= '0;
      fu_rsp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      occ_q          <= occ_d;
      tag_q          <= tag_d;
      lane_q         <= lane_d;
      cnt_q          <= cnt_d;
      c0_req_valid_q <= c0_req_valid_d;
      c0_req_addr_q  <= c0_req_addr_d;
      c0_req_mdata_q <= c0_req_mdata_d;
      fu_rsp_valid_q <= fu_rsp_valid_d;
      fu_rsp_tag_q   <= fu_rsp_tag_d;
      fu_rsp_data_q  <= fu_rsp_data_d;
      err_q          <= err_d;
    end
  end

  assign c0_req_valid    = c0_req_valid_q;
  assign c0_req_addr     = c0_req_addr_q;
  assign c0_req_mdata    = c0_req_mdata_q;
  assign fu_rsp_valid    = fu_rsp_valid_q;
  assign fu_rsp_tag      = fu_rsp_tag_q;
  assign fu_rsp_data     = fu_rsp_data_q;
  assign outstanding     = cnt_q;
  assign err_unknown_tag = err_q;

endmodule
